icache_refill_ctrl: RTL and testbench
=====================================

Name: icache_refill_ctrl

Overview:
- Parametrised instruction-cache refill controller for the Fetch Unit.
- Sits between the fetch PC/i_cache hit signal and RAM.
- On a miss it latches the line address and issues one word read per RAM handshake, collecting BLOCK_WORDS words into a line buffer.
- When the line is complete it pulses a one-cycle cache write enable with the assembled line, then returns to idle.
- Generalises the fixed-geometry refill path: configurable word width, line size and PC width, a real registered FSM, abort on flush, and optional critical-word-first fill.

Parameters:
- PC_W, 32, program counter / RAM address width in bits.
- WORD_W, 32, width of one RAM word in bits (multiple of 8).
- BLOCK_WORDS, 16, words per cache line (power of 2, >=2). Line = BLOCK_WORDS*WORD_W bits.
- OFF_W, derived = log2(BLOCK_WORDS*WORD_W/8), byte-offset bits of a line. Default 6.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- pc  in  PC_W  fetch program counter.
- pc_valid  in  1  pc carries a real fetch request this cycle.
- hit  in  1  i_cache hit for pc (combinational from i_cache).
- flush  in  1  abort any refill (branch redirect / fence.i).
- mem_word  in  WORD_W  data word from RAM.
- word_ready  in  1  mem_word valid this cycle; one word per asserted cycle.
- ram_req  out  1  read request to RAM, held while words are outstanding.
- ram_address  out  PC_W  byte address of the word currently requested.
- we_cache  out  1  i_cache line write enable, one-cycle pulse.
- block_out  out  BLOCK_WORDS*WORD_W  assembled line; word 0 in the MS bits, matching i_cache block_in ordering.
- cache_miss  out  1  stall to the Fetch Unit.
- refill_busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset values: rst=1 at a clock edge forces the following, whatever the current state:
  - state=IDLE, word counter=0, line base=0, line buffer=0.
  - ram_req=0, we_cache=0, ram_address=0, refill_busy=0.
  - cache_miss=0 while rst is high.
- IDLE:
  - ram_req=0, we_cache=0.
  - cache_miss = pc_valid & ~hit (combinational).
  - If pc_valid & ~hit & ~flush: latch base = {pc[PC_W-1:OFF_W], OFF_W'b0}, set cnt=0, go to FILL.
- FILL:
  - ram_req=1, cache_miss=1.
  - ram_address = base + cnt*(WORD_W/8), registered.
  - On word_ready: buffer[cnt] <= mem_word and cnt <= cnt+1.
  - When word_ready arrives with cnt==BLOCK_WORDS-1, go to WRITE. The counter wraps to 0 and is not used further.
  - word_ready deasserted: hold state and address; there is no timeout.
- WRITE:
  - ram_req=0, we_cache=1 for exactly this cycle, block_out stable, cache_miss=1.
  - Next state is IDLE unconditionally.
  - i_cache reports hit for the same pc on the following cycle, so cache_miss drops then.
- Latency: miss seen in cycle 0 with words returned back-to-back gives we_cache in cycle BLOCK_WORDS+1. Minimum miss penalty is BLOCK_WORDS+2 cycles.
- pc changes during FILL/WRITE are ignored; the refill always completes for the latched base.
- flush:
  - In FILL or WRITE, the next state is IDLE with no we_cache pulse.
  - A WRITE-cycle flush suppresses the pulse in that same cycle (we_cache = WRITE & ~flush).
  - Buffer contents are don't-care afterwards.
  - In IDLE, flush blocks a new refill start for that cycle.
- word_ready outside FILL is ignored and does not change the buffer or counter.
- block_out reflects the buffer at all times; it is only guaranteed valid while we_cache=1.
- Simultaneous rst and flush: rst wins.

Optional Feature:
- Macro: ICACHE_CRITICAL_WORD_FIRST_EN.
- Defined:
  - The FILL counter starts at pc[OFF_W-1:log2(WORD_W/8)] (the missed word) and wraps modulo BLOCK_WORDS.
  - Each word is stored in buffer slot = its counter value.
  - Exactly BLOCK_WORDS words are taken.
  - Extra ports, present only with the macro: crit_valid (out, 1), a one-cycle pulse on the first word_ready of a refill; crit_word (out, WORD_W) = that word.
- Undefined: the counter always starts at 0, and the crit_* ports do not exist.
- In both cases we_cache timing and block_out ordering are identical.

Test Plan:
- Basic refill: default params, pc=0x1234 miss, word_ready every cycle, data=0xA000+i. Required:
  - ram_address steps 0x1200, 0x1204 … 0x123C.
  - we_cache pulses exactly once, 17 cycles after the miss.
  - block_out[511:480]=0xA000 and block_out[31:0]=0xA00F.
- Gapped RAM: word_ready asserted every 3rd cycle. Required: ram_address holds between words, the FSM stays in FILL, and we_cache is still a single pulse after the 16th word.
- Flush mid-refill: flush asserted after the 5th word. Required:
  - next cycle state=IDLE, ram_req=0, no we_cache.
  - a new miss at pc=0x2000 restarts at ram_address 0x2000.
- Reset mid-refill: rst asserted during FILL, and separately during WRITE. Required: all outputs at reset values the next cycle and no we_cache pulse.
- Geometry: WORD_W=64, BLOCK_WORDS=4 (OFF_W=5), pc=0x104C. Required: addresses 0x1040, 0x1048, 0x1050, 0x1058, and the we_cache pulse after the 4th word.
- ICACHE_CRITICAL_WORD_FIRST_EN defined, default params, pc=0x1234. Required:
  - first address 0x1234, wraps 0x123C → 0x1200 … 0x1230.
  - crit_valid pulses with the first word.
  - block_out word 13 holds the first-returned data.

Source files
------------

// File: rtl/icache_refill_ctrl.sv
// ----------------------------------------------------------------------------
// icache_refill_ctrl
//
// Instruction-cache refill controller. It sits between the Fetch Unit and RAM.
// On a miss it latches the line base address. It then requests one word per
// RAM handshake and assembles BLOCK_WORDS words into a line buffer. When the
// line is complete it pulses o_we_cache for one cycle so the i_cache can
// capture the line. A flush aborts any refill that is in flight.
//
// Optional build macro:
//   ICACHE_CRITICAL_WORD_FIRST_EN
//       The fill starts at the missed word and wraps around the line.
//       Adds the o_crit_valid and o_crit_word ports.
//
// Ports:
//   i_clk            clock; all state updates on the rising edge
//   i_rst            synchronous reset, active-high
//   i_pc             fetch program counter
//   i_pc_valid       i_pc carries a real fetch request this cycle
//   i_hit            i_cache hit for i_pc (combinational from i_cache)
//   i_flush          abort any refill (branch redirect / fence.i)
//   i_mem_word       data word from RAM
//   i_word_ready     i_mem_word valid this cycle; one word per asserted cycle
//   o_ram_req        read request to RAM, held while words are outstanding
//   o_ram_address    byte address of the word currently requested
//   o_we_cache       i_cache line write enable, one-cycle pulse
//   o_block_out      assembled line; word 0 in the MS bits
//   o_cache_miss     stall to the Fetch Unit
//   o_refill_busy    FSM is not in IDLE
//   o_crit_valid     (macro only) pulse on the first word of a refill
//   o_crit_word      (macro only) that first word
//
// States:
//   S_IDLE  | waiting for a miss; the miss signal follows pc_valid & ~hit
//   S_FILL  | requesting and collecting words from RAM
//   S_WRITE | one-cycle line write into the i_cache
// ----------------------------------------------------------------------------
module icache_refill_ctrl #(
    parameter int PC_W        = 32,
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [PC_W-1:0]               i_pc,
    input  logic                          i_pc_valid,
    input  logic                          i_hit,
    input  logic                          i_flush,
    input  logic [WORD_W-1:0]             i_mem_word,
    input  logic                          i_word_ready,
    output logic                          o_ram_req,
    output logic [PC_W-1:0]               o_ram_address,
    output logic                          o_we_cache,
    output logic [BLOCK_WORDS*WORD_W-1:0] o_block_out,
    output logic                          o_cache_miss,
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    output logic                          o_crit_valid,
    output logic [WORD_W-1:0]             o_crit_word,
`endif
    output logic                          o_refill_busy
);

    localparam int BYTE_W  = WORD_W / 8;
    localparam int BYTE_SH = $clog2(BYTE_W);
    localparam int OFF_W   = $clog2(BLOCK_WORDS * BYTE_W);
    localparam int CNT_W   = $clog2(BLOCK_WORDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t                           r_state;
    state_t                           w_state_nxt;
    logic [CNT_W-1:0]                 r_cnt;
    logic [CNT_W-1:0]                 w_cnt_inc;
    logic [CNT_W-1:0]                 w_start_cnt;
    logic [PC_W-1:0]                  r_base;
    logic [PC_W-1:0]                  r_addr;
    logic [PC_W-1:0]                  w_line_base;
    logic [BLOCK_WORDS-1:0][WORD_W-1:0] r_buf;
    logic                             w_start;
    logic                             w_take;
    logic                             w_last;
    logic                             w_unused_pc_lo;

    assign w_line_base = {i_pc[PC_W-1:OFF_W], {OFF_W{1'b0}}};
    assign w_cnt_inc   = r_cnt + CNT_W'(1);
    assign w_start     = (r_state == S_IDLE) & i_pc_valid & ~i_hit & ~i_flush;
    assign w_take      = (r_state == S_FILL) & i_word_ready;

    // The offset bits of the pc only select the starting word in the
    // critical-word-first build. In the default build they are not used.
    assign w_unused_pc_lo = ^i_pc[OFF_W-1:0];

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    logic [CNT_W-1:0] r_start_cnt;
    logic             r_first;

    assign w_start_cnt = i_pc[OFF_W-1:BYTE_SH];
    // The line is complete when the wrapped counter comes back to its start.
    assign w_last      = (w_cnt_inc == r_start_cnt);
    assign o_crit_valid = w_take & r_first;
    assign o_crit_word  = i_mem_word;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_start_cnt <= '0;
            r_first     <= 1'b0;
        end else if (w_start) begin
            r_start_cnt <= w_start_cnt;
            r_first     <= 1'b1;
        end else if (w_take) begin
            r_first     <= 1'b0;
        end
    end
`else
    assign w_start_cnt = '0;
    assign w_last      = (r_cnt == CNT_W'(BLOCK_WORDS - 1));
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_base  <= '0;
            r_addr  <= '0;
            r_buf   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_base <= w_line_base;
                r_cnt  <= w_start_cnt;
                r_addr <= w_line_base | (PC_W'(w_start_cnt) << BYTE_SH);
            end else if (w_take) begin
                r_buf[r_cnt] <= i_mem_word;
                r_cnt        <= w_cnt_inc;
                // The base is line aligned, so OR-ing in the word offset
                // gives the same result as adding it.
                r_addr       <= r_base | (PC_W'(w_cnt_inc) << BYTE_SH);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_ram_req    = 1'b0;
        o_we_cache   = 1'b0;
        o_cache_miss = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_cache_miss = i_pc_valid & ~i_hit;
                if (w_start) begin
                    w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                o_ram_req    = 1'b1;
                o_cache_miss = 1'b1;
                if (i_flush) begin
                    w_state_nxt = S_IDLE;
                end else if (w_take && w_last) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                // A flush or reset in the write cycle drops the line.
                o_we_cache   = ~i_flush & ~i_rst;
                o_cache_miss = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (i_rst) begin
            o_cache_miss = 1'b0;
        end
    end

    // Buffer slot 0 goes to the most significant word of the line.
    always_comb begin
        o_block_out = '0;
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            o_block_out[(BLOCK_WORDS-1-i)*WORD_W +: WORD_W] = r_buf[i];
        end
    end

    assign o_ram_address = r_addr;
    assign o_refill_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// ----------------------------------------------------------------------------
// tb_icache_refill_ctrl
//
// Directed bench for icache_refill_ctrl. It uses two instances: dut_a with the
// default geometry and dut_b with 64-bit words and 4-word lines. Expected
// addresses and lines come from the pc and from the data pattern this bench
// drives. The starting word depends on ICACHE_CRITICAL_WORD_FIRST_EN.
// ----------------------------------------------------------------------------
module tb_icache_refill_ctrl;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;

    logic [31:0]  a_pc;
    logic         a_pc_valid, a_hit, a_flush, a_word_ready;
    logic [31:0]  a_mem_word;
    logic         a_ram_req, a_we, a_miss, a_busy;
    logic [31:0]  a_ram_address;
    logic [511:0] a_block;

    logic [31:0]  b_pc;
    logic         b_pc_valid, b_hit, b_flush, b_word_ready;
    logic [63:0]  b_mem_word;
    logic         b_ram_req, b_we, b_miss, b_busy;
    logic [31:0]  b_ram_address;
    logic [255:0] b_block;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    logic         a_crit_valid, b_crit_valid;
    logic [31:0]  a_crit_word;
    logic [63:0]  b_crit_word;
`endif

    icache_refill_ctrl #(.PC_W(32), .WORD_W(32), .BLOCK_WORDS(16)) dut_a (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_pc         (a_pc),
        .i_pc_valid   (a_pc_valid),
        .i_hit        (a_hit),
        .i_flush      (a_flush),
        .i_mem_word   (a_mem_word),
        .i_word_ready (a_word_ready),
        .o_ram_req    (a_ram_req),
        .o_ram_address(a_ram_address),
        .o_we_cache   (a_we),
        .o_block_out  (a_block),
        .o_cache_miss (a_miss),
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        .o_crit_valid (a_crit_valid),
        .o_crit_word  (a_crit_word),
`endif
        .o_refill_busy(a_busy)
    );

    icache_refill_ctrl #(.PC_W(32), .WORD_W(64), .BLOCK_WORDS(4)) dut_b (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_pc         (b_pc),
        .i_pc_valid   (b_pc_valid),
        .i_hit        (b_hit),
        .i_flush      (b_flush),
        .i_mem_word   (b_mem_word),
        .i_word_ready (b_word_ready),
        .o_ram_req    (b_ram_req),
        .o_ram_address(b_ram_address),
        .o_we_cache   (b_we),
        .o_block_out  (b_block),
        .o_cache_miss (b_miss),
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        .o_crit_valid (b_crit_valid),
        .o_crit_word  (b_crit_word),
`endif
        .o_refill_busy(b_busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // One refill on dut_a. Word k returns 0xA000+k. gap: word_ready every gap-th cycle.
    // abort_at: words taken before abort (-1 none, 16 = abort in WRITE); abort_rst selects rst vs flush.
    task automatic do_refill(input logic [31:0] pc_in, input int gap, input int abort_at,
                             input bit abort_rst, output logic [511:0] line);
        logic [31:0] base;
        logic [3:0]  start;
        int          slot;
        line  = '0;
        base  = pc_in & 32'hFFFF_FFC0;
        start = CWF ? pc_in[5:2] : 4'd0;
        a_pc = pc_in; a_pc_valid = 1'b1; a_hit = 1'b0;
        settle();
        chk("miss_in_idle", a_miss, 1'b1);
        chk("no_req_in_idle", a_ram_req, 1'b0);
        tick();
        a_pc_valid = 1'b0;
        a_pc = 32'hFFFF_FFF0;
        for (int k = 0; k <= 16; k++) begin
            if (k == abort_at) begin
                if (abort_rst) rst = 1'b1; else a_flush = 1'b1;
                a_word_ready = 1'b0;
                settle();
                chk("abort_no_we", a_we, 1'b0);
                if (abort_rst) chk("miss_low_in_rst", a_miss, 1'b0);
                tick();
                rst = 1'b0; a_flush = 1'b0;
                settle();
                chk("abort_idle_busy", a_busy, 1'b0);
                chk("abort_idle_req", a_ram_req, 1'b0);
                chk("abort_idle_we", a_we, 1'b0);
                if (abort_rst) begin
                    chk("rst_addr", a_ram_address, 32'h0);
                    chk("rst_block", a_block, 512'h0);
                    chk("rst_miss", a_miss, 1'b0);
                end
                tick();
                return;
            end
            if (k == 16) break;
            slot = (int'(start) + k) % 16;
            for (int g = 0; g < gap - 1; g++) begin
                a_word_ready = 1'b0;
                a_mem_word   = 32'hDEAD_BEEF;
                settle();
                chk("gap_addr_hold", a_ram_address, base + 32'(slot * 4));
                chk("gap_req", a_ram_req, 1'b1);
                chk("gap_busy", a_busy, 1'b1);
                tick();
            end
            a_word_ready = 1'b1;
            a_mem_word   = 32'hA000 + 32'(k);
            line[(15 - slot) * 32 +: 32] = 32'hA000 + 32'(k);
            settle();
            chk("fill_addr", a_ram_address, base + 32'(slot * 4));
            chk("fill_req", a_ram_req, 1'b1);
            chk("fill_no_we", a_we, 1'b0);
            chk("fill_miss", a_miss, 1'b1);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
            chk("crit_valid", a_crit_valid, (k == 0));
            if (k == 0) chk("crit_word", a_crit_word, 32'hA000);
`endif
            tick();
        end
        a_word_ready = 1'b0;
        settle();
        chk("write_we", a_we, 1'b1);
        chk("write_req", a_ram_req, 1'b0);
        chk("write_miss", a_miss, 1'b1);
        chk("write_block", a_block, line);
        tick();
        a_pc = pc_in; a_pc_valid = 1'b1; a_hit = 1'b1;
        settle();
        chk("post_we", a_we, 1'b0);
        chk("post_busy", a_busy, 1'b0);
        chk("post_miss", a_miss, 1'b0);
        tick();
        a_pc_valid = 1'b0; a_hit = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [511:0] line;
        logic [255:0] line_b;
        logic [1:0]   start_b;
        int           slot;

        rst = 1'b1;
        a_pc = 32'h0; a_pc_valid = 1'b1; a_hit = 1'b0; a_flush = 1'b0;
        a_mem_word = 32'h0; a_word_ready = 1'b0;
        b_pc = 32'h0; b_pc_valid = 1'b0; b_hit = 1'b0; b_flush = 1'b0;
        b_mem_word = 64'h0; b_word_ready = 1'b0;
        tick();
        tick();
        settle();
        chk("rst_miss_gated", a_miss, 1'b0);
        chk("rst_req", a_ram_req, 1'b0);
        chk("rst_we", a_we, 1'b0);
        chk("rst_addr0", a_ram_address, 32'h0);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_block0", a_block, 512'h0);
        chk("rst_b_addr", b_ram_address, 32'h0);
        tick();
        rst = 1'b0; a_pc_valid = 1'b0;
        tick();

        // Basic refill, then word_ready in IDLE must leave the line alone.
        do_refill(32'h1234, 1, -1, 1'b0, line);
        a_word_ready = 1'b1; a_mem_word = 32'h5555_5555;
        settle();
        chk("idle_wr_req", a_ram_req, 1'b0);
        tick();
        a_word_ready = 1'b0;
        settle();
        chk("idle_wr_block", a_block, line);
        chk("idle_wr_busy", a_busy, 1'b0);
        tick();

        // A flush in IDLE blocks the refill start.
        a_pc = 32'h1234; a_pc_valid = 1'b1; a_hit = 1'b0; a_flush = 1'b1;
        settle();
        chk("idle_flush_miss", a_miss, 1'b1);
        tick();
        a_pc_valid = 1'b0; a_flush = 1'b0;
        settle();
        chk("idle_flush_busy", a_busy, 1'b0);
        chk("idle_flush_req", a_ram_req, 1'b0);
        tick();

        do_refill(32'h5678, 3, -1, 1'b0, line);
        do_refill(32'h1234, 1, 5, 1'b0, line);
        do_refill(32'h2000, 1, -1, 1'b0, line);
        do_refill(32'h3310, 1, 7, 1'b1, line);
        do_refill(32'h3310, 1, 16, 1'b1, line);
        do_refill(32'h4400, 1, 16, 1'b0, line);

        // Geometry: 64-bit words, 4-word lines.
        start_b = CWF ? 2'd1 : 2'd0;
        line_b  = '0;
        b_pc = 32'h104C; b_pc_valid = 1'b1; b_hit = 1'b0;
        settle();
        chk("b_miss", b_miss, 1'b1);
        tick();
        b_pc_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            slot = (int'(start_b) + k) % 4;
            b_word_ready = 1'b1;
            b_mem_word   = 64'hB0B0_0000_0000_0000 | 64'(k);
            line_b[(3 - slot) * 64 +: 64] = 64'hB0B0_0000_0000_0000 | 64'(k);
            settle();
            chk("b_addr", b_ram_address, 32'h1040 + 32'(slot * 8));
            chk("b_no_we", b_we, 1'b0);
            chk("b_req", b_ram_req, 1'b1);
            tick();
        end
        b_word_ready = 1'b0;
        settle();
        chk("b_we", b_we, 1'b1);
        chk("b_block", b_block, line_b);
        tick();
        b_pc_valid = 1'b1; b_hit = 1'b1;
        settle();
        chk("b_post_we", b_we, 1'b0);
        chk("b_post_busy", b_busy, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
